// File: rtl/inst_encoder.sv
// ============================================================================
// Module      : inst_encoder
// Description : Packs RV32I fields into instruction words and streams them to
//               instruction memory at consecutive word addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_encoder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_format,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  mem_write_en,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic [1:0]            err_flags
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   WORDS_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [1:0]            err_q, err_d;

  logic        w_fmt_ok;
  logic        w_imm_ok;
  logic [31:0] w_enc;
  logic        w_accept;
  logic        w_fire;

  // Sign-extension checks: the upper immediate bits must be all copies of the
  // format's sign bit for the value to survive the decoder's extension.
  logic w_sx11, w_sx12, w_sx20;
  assign w_sx11 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign w_sx12 = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign w_sx20 = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    w_enc    = 32'h0;
    w_fmt_ok = 1'b1;
    w_imm_ok = 1'b1;
    case (in_format)
      FMT_R: w_enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        w_enc    = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_imm_ok = w_sx11;
      end
      FMT_S: begin
        w_enc    = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_imm_ok = w_sx11;
      end
      FMT_B: begin
        w_enc    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        w_imm_ok = w_sx12 && !in_imm[0];
      end
      FMT_U: begin
        w_enc    = {in_imm[31:12], in_rd, in_opcode};
        w_imm_ok = !(|in_imm[11:0]);
      end
      FMT_J: begin
        w_enc    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        w_imm_ok = w_sx20 && !in_imm[0];
      end
      default: w_fmt_ok = 1'b0;
    endcase
  end

  assign in_ready = !start && (!out_valid_q || mem_ready);
  assign w_accept = in_valid && in_ready;
  assign w_fire   = out_valid_q && mem_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    words_d     = words_q;
    err_d       = err_q;
    if (start) begin
      out_valid_d = 1'b0;
      addr_d      = start_addr;
      words_d     = '0;
      err_d       = 2'b00;
    end else begin
      if (w_fire) begin
        out_valid_d = 1'b0;
        addr_d      = addr_q + ADDR_ONE;
        if (words_q != '1) begin
          words_d = words_q + WORDS_ONE;
        end
      end
      // Rejected bundles are consumed but leave the output stage untouched.
      if (w_accept) begin
        if (!w_fmt_ok) begin
          err_d[0] = 1'b1;
        end else if (!w_imm_ok) begin
          err_d[1] = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          data_d      = w_enc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= 32'h0;
      words_q     <= '0;
      err_q       <= 2'b00;
    end else begin
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      words_q     <= words_d;
      err_q       <= err_d;
    end
  end

  assign mem_write_en  = out_valid_q;
  assign mem_addr      = addr_q;
  assign mem_data      = data_q;
  assign words_written = words_q;
  assign err_flags     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
// Module      : tb_inst_encoder
// Description : Directed plus randomized self-checking bench for inst_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_encoder;

  localparam int AW   = 8;
  localparam int MAXW = (1 << (AW + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_format;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          mem_write_en;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic [AW:0]   words_written;
  logic [1:0]    err_flags;

  int n_cmp = 0;
  int n_bad = 0;

  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  int            m_words;
  logic [1:0]    m_err;

  inst_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_format(in_format),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_write_en(mem_write_en), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .words_written(words_written), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from shifted/masked fields.
  function automatic logic [31:0] ref_word(input logic [31:0] fmt, opc, rd, rs1, rs2,
                                           f3, f7, imm);
    logic [31:0] w;
    w = opc;
    case (fmt)
      0: w |= (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
      1: w |= (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      2: w |= ((imm & 32'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
              | (((imm >> 5) & 32'h7F) << 25);
      3: w |= (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8) | (f3 << 12)
              | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 32'h3F) << 25)
              | (((imm >> 12) & 32'h1) << 31);
      4: w |= (rd << 7) | (imm & 32'hFFFFF000);
      5: w |= (rd << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
              | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Legality as signed ranges and alignment.
  function automatic bit ref_legal(input logic [31:0] fmt, imm);
    int s;
    s = imm;
    case (fmt)
      1, 2:    return (s >= -2048) && (s <= 2047);
      3:       return ((s % 2) == 0) && (s >= -4096) && (s <= 4095);
      4:       return (imm % 32'd4096) == 0;
      5:       return ((s % 2) == 0) && (s >= -1048576) && (s <= 1048575);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_addr  = '0;
    m_data  = 32'h0;
    m_words = 0;
    m_err   = 2'b00;
  endtask

  task automatic set_bundle(input logic [2:0] fmt, input logic [6:0] opc,
                            input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_format = fmt;
    in_opcode = opc;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  task automatic tick();
    bit fire, acc;
    #1;
    check("in_ready", {31'b0, in_ready}, {31'b0, !start && (!m_valid || mem_ready)});
    fire = m_valid && mem_ready;
    acc  = in_valid && !start && (!m_valid || mem_ready);
    @(posedge clk);
    #1;
    if (start) begin
      m_valid = 1'b0;
      m_addr  = start_addr;
      m_words = 0;
      m_err   = 2'b00;
    end else begin
      if (fire) begin
        m_valid = 1'b0;
        m_addr  = m_addr + 1'b1;
        if (m_words < MAXW) m_words++;
      end
      if (acc) begin
        if (in_format > 3'd5) m_err[0] = 1'b1;
        else if (!ref_legal(32'(in_format), in_imm)) m_err[1] = 1'b1;
        else begin
          m_valid = 1'b1;
          m_data  = ref_word(32'(in_format), 32'(in_opcode), 32'(in_rd), 32'(in_rs1),
                             32'(in_rs2), 32'(in_funct3), 32'(in_funct7), in_imm);
        end
      end
    end
    check("write_en", {31'b0, mem_write_en}, {31'b0, m_valid});
    check("addr", 32'(mem_addr), 32'(m_addr));
    check("words", 32'(words_written), m_words);
    check("err", 32'(err_flags), 32'(m_err));
    if (m_valid) check("data", mem_data, m_data);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, {31'b0, mem_write_en}, 32'h0);
    check({tag, "_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_data"}, mem_data, 32'h0);
    check({tag, "_words"}, 32'(words_written), 32'h0);
    check({tag, "_err"}, 32'(err_flags), 32'h0);
  endtask

  initial begin
    logic [31:0] r, imm;
    logic [2:0]  fmt;

    rst = 1'b1; start = 1'b0; start_addr = '0; mem_ready = 1'b1;
    set_bundle(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    in_valid = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'b0, in_ready}, 32'h1);

    // First program word
    start = 1'b1; start_addr = 8'h10;
    tick();
    start = 1'b0;
    set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    check("I_data", mem_data, 32'h00500093);
    check("I_addr", 32'(mem_addr), 32'h10);
    in_valid = 1'b0;
    tick();
    check("I_words", 32'(words_written), 32'h1);

    // Back-to-back
    set_bundle(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
    tick();
    check("R_data", mem_data, 32'h002081B3);
    check("R_addr", 32'(mem_addr), 32'h11);
    set_bundle(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    check("S_data", mem_data, 32'h0020A423);
    check("S_addr", 32'(mem_addr), 32'h12);
    set_bundle(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    tick();
    check("B_data", mem_data, 32'hFE208EE3);
    check("B_addr", 32'(mem_addr), 32'h13);
    set_bundle(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    tick();
    check("U_data", mem_data, 32'h123452B7);
    check("U_addr", 32'(mem_addr), 32'h14);
    in_valid = 1'b0;
    tick();
    check("b2b_words", 32'(words_written), 32'h5);

    // Rejects, then an undelayed valid bundle
    set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    check("rej_imm_err", 32'(err_flags), 32'h2);
    check("rej_imm_we", {31'b0, mem_write_en}, 32'h0);
    check("rej_imm_addr", 32'(mem_addr), 32'h15);
    check("rej_imm_words", 32'(words_written), 32'h5);
    set_bundle(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    check("rej_fmt_err", 32'(err_flags), 32'h3);
    set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    check("after_rej_we", {31'b0, mem_write_en}, 32'h1);
    in_valid = 1'b0;
    tick();
    start = 1'b1; start_addr = 8'h20;
    tick();
    start = 1'b0;
    check("start_err_clr", 32'(err_flags), 32'h0);

    // Backpressure
    mem_ready = 1'b0;
    set_bundle(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    tick();
    set_bundle(3'd0, 7'h33, 5'd4, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_data", mem_data, 32'h00700113);
      check("bp_addr", 32'(mem_addr), 32'h20);
      check("bp_ready", {31'b0, in_ready}, 32'h0);
    end
    mem_ready = 1'b1;
    tick();
    check("bp_next_data", mem_data, 32'h00310233);
    check("bp_next_addr", 32'(mem_addr), 32'h21);
    in_valid = 1'b0;
    tick();
    check("bp_words", 32'(words_written), 32'h2);

    // Address wrap
    start = 1'b1; start_addr = 8'hFF;
    tick();
    start = 1'b0;
    set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    check("wrap_addr0", 32'(mem_addr), 32'hFF);
    set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    tick();
    check("wrap_addr1", 32'(mem_addr), 32'h00);
    in_valid = 1'b0;
    tick();
    check("wrap_words", 32'(words_written), 32'h2);

    // Start while stalled
    mem_ready = 1'b0;
    set_bundle(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
    tick();
    in_valid = 1'b0; start = 1'b1; start_addr = 8'h40;
    tick();
    start = 1'b0;
    check("stall_start_we", {31'b0, mem_write_en}, 32'h0);
    check("stall_start_addr", 32'(mem_addr), 32'h40);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      start      = (r[5:0] == 6'd0);
      start_addr = r[15:8];
      mem_ready  = (r[17:16] != 2'b00);
      r = $urandom;
      fmt = (r[3:0] >= 4'd14) ? {2'b11, r[0]} : 3'(r[3:0] % 4'd6);
      imm = $urandom;
      if (r[6:4] != 3'd0) begin
        case (fmt)
          3'd1, 3'd2: imm = {{20{imm[11]}}, imm[11:0]};
          3'd3:       imm = {{19{imm[12]}}, imm[12:1], 1'b0};
          3'd4:       imm = {imm[31:12], 12'h0};
          3'd5:       imm = {{11{imm[20]}}, imm[20:1], 1'b0};
          default:    imm = imm;
        endcase
      end
      set_bundle(fmt, r[13:7], r[18:14], r[23:19], r[28:24], r[31:29], r[11:5], imm);
      in_valid = (r[1:0] != 2'b00) || r[2];
      tick();
    end
    start = 1'b0;

    // Asynchronous reset mid-write
    mem_ready = 1'b0;
    set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    tick();
    check("pre_rst_we", {31'b0, mem_write_en}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
